// File: rtl/keypad_if.sv
// Keypad debouncer bus: scanner row/column samples in, debounced key handshake out.
interface keypad_if;
    logic [3:0] row;
    logic [3:0] col;
    logic       key_ready;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;
    logic       overrun;

    modport master (
        output row, col, key_ready,
        input  key_valid, key_code, key_held, overrun
    );

    modport slave (
        input  row, col, key_ready,
        output key_valid, key_code, key_held, overrun
    );
endinterface

// File: rtl/keypad_debouncer.sv
// Folds one-hot row scans into per-sweep results, debounces whole sweeps and
// presents each accepted press once on a valid/ready handshake.
module keypad_debouncer #(
    parameter int unsigned DEBOUNCE_SWEEPS = 8
) (
    input  logic    clk,
    input  logic    rst_n,
    keypad_if.slave kp
);
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_KEY   = 2'd1,
        RES_MULTI = 2'd2
    } sweep_res_t;

    localparam logic [7:0] CNT_TARGET = 8'(DEBOUNCE_SWEEPS);

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] idx4(input logic [3:0] v);
        logic [1:0] i;
        i = 2'd0;
        for (int b = 0; b < 4; b++) begin
            if (v[b]) i = 2'(b);
        end
        return i;
    endfunction

    // Hit counts saturate at 2: anything beyond one hit is simply MULTI.
    function automatic logic [1:0] sat_add2(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > 3'd2) ? 2'd2 : s[1:0];
    endfunction

    // ---- stage p0: classify the current row/col sample
    logic       vld_p0;
    logic       sweep_end_p0;
    logic [1:0] hits_p0;
    logic [3:0] hit_code_p0;

    always_comb begin
        vld_p0       = is_onehot4(kp.row);
        sweep_end_p0 = vld_p0 && kp.row[3];
        hit_code_p0  = {idx4(kp.row), idx4(kp.col)};
        hits_p0      = 2'd0;
        if (vld_p0 && (kp.col != 4'd0)) begin
            hits_p0 = is_onehot4(kp.col) ? 2'd1 : 2'd2;
        end
    end

    // ---- sweep accumulator: the row-3 sample is merged before the result is taken
    logic [1:0] acc_hits;
    logic [3:0] acc_code;
    logic [1:0] tot_hits;
    logic [3:0] tot_code;
    sweep_res_t res;

    always_comb begin
        tot_hits = sat_add2(acc_hits, hits_p0);
        tot_code = (acc_hits == 2'd0) ? hit_code_p0 : acc_code;
        res      = RES_NONE;
        if (tot_hits == 2'd1) begin
            res = RES_KEY;
        end else if (tot_hits == 2'd2) begin
            res = RES_MULTI;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hits <= 2'd0;
            acc_code <= 4'd0;
        end else if (sweep_end_p0) begin
            acc_hits <= 2'd0;
            acc_code <= 4'd0;
        end else if (vld_p0) begin
            acc_hits <= tot_hits;
            acc_code <= tot_code;
        end
    end

    // ---- debounce FSM, stepped only on sweep-end samples
    state_t     state, state_d;
    logic [7:0] cnt, cnt_d;
    logic [3:0] cand, cand_d;
    logic [7:0] cnt_inc;
    logic       cnt_done;
    logic       emit;
    logic [3:0] emit_code;

    assign cnt_inc  = cnt + 8'd1;
    assign cnt_done = (cnt_inc >= CNT_TARGET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
            cand  <= 4'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            cand  <= cand_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        cand_d    = cand;
        emit      = 1'b0;
        emit_code = cand;
        if (sweep_end_p0) begin
            unique case (state)
                IDLE: begin
                    if (res == RES_KEY) begin
                        cand_d = tot_code;
                        cnt_d  = 8'd1;
                        if (CNT_TARGET <= 8'd1) begin
                            state_d   = PRESSED;
                            emit      = 1'b1;
                            emit_code = tot_code;
                        end else begin
                            state_d = PRESS_WAIT;
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (res != RES_KEY) begin
                        state_d = IDLE;
                    end else if (tot_code == cand) begin
                        cnt_d = cnt_inc;
                        if (cnt_done) begin
                            state_d   = PRESSED;
                            emit      = 1'b1;
                            emit_code = cand;
                        end
                    end else begin
                        cand_d = tot_code;
                        cnt_d  = 8'd1;
                    end
                end
                PRESSED: begin
                    if (res == RES_NONE) begin
                        cnt_d   = 8'd1;
                        state_d = (CNT_TARGET <= 8'd1) ? IDLE : RELEASE_WAIT;
                    end
                end
                RELEASE_WAIT: begin
                    if (res == RES_NONE) begin
                        cnt_d = cnt_inc;
                        if (cnt_done) state_d = IDLE;
                    end else begin
                        state_d = PRESSED;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ---- output handshake: a press landing on an un-acked code is dropped
    logic       key_valid_q;
    logic [3:0] key_code_q;
    logic       overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
            overrun_q   <= 1'b0;
        end else begin
            if (emit && (!key_valid_q || kp.key_ready)) begin
                key_valid_q <= 1'b1;
                key_code_q  <= emit_code;
            end else if (key_valid_q && kp.key_ready) begin
                key_valid_q <= 1'b0;
            end
            if (emit && key_valid_q && !kp.key_ready) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign kp.key_valid = key_valid_q;
    assign kp.key_code  = key_code_q;
    assign kp.overrun   = overrun_q;
    assign kp.key_held  = (state == PRESSED) || (state == RELEASE_WAIT);

endmodule

// File: tb/tb_keypad_debouncer.sv
// Bench for keypad_debouncer: directed and random keypad sweeps against a
// sweep-level reference model, with a queue-based scoreboard on the handshake.
module tb_keypad_debouncer;
    localparam int N = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    keypad_if bus ();

    keypad_debouncer #(.DEBOUNCE_SWEEPS(N)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .kp   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    int rdy_mode = 1;   // 0: never ready, 1: always ready, 2: random

    // Reference model state
    int exp_q[$];
    int hits_q[$];
    bit held;
    int run_key, run_len, rel_len;
    bit m_valid, m_over;
    int m_code;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        hits_q.delete();
        held = 0; run_key = 0; run_len = 0; rel_len = 0;
        m_valid = 0; m_over = 0; m_code = 0;
    endtask

    // One clock of the keypad as the specification describes it: collect hits
    // per sweep, judge the sweep at row 3, then debounce and hand off.
    task automatic model_cycle(input logic [3:0] r, input logic [3:0] c, input bit rdy);
        bit emit = 0;
        int ek   = 0;
        if (r == 4'd1 || r == 4'd2 || r == 4'd4 || r == 4'd8) begin
            for (int j = 0; j < 4; j++)
                if (c[j]) hits_q.push_back($clog2(r) * 4 + j);
            if (r == 4'd8) begin
                if (!held) begin
                    if (hits_q.size() == 1) begin
                        if (run_len > 0 && hits_q[0] == run_key) run_len++;
                        else begin run_key = hits_q[0]; run_len = 1; end
                        if (run_len == N) begin
                            held = 1; run_len = 0; rel_len = 0;
                            emit = 1; ek = run_key;
                        end
                    end else begin
                        run_len = 0;
                    end
                end else begin
                    if (hits_q.size() == 0) begin
                        rel_len++;
                        if (rel_len == N) begin held = 0; rel_len = 0; end
                    end else begin
                        rel_len = 0;
                    end
                end
                hits_q.delete();
            end
        end
        if (emit) begin
            if (!m_valid || rdy) begin
                m_valid = 1; m_code = ek; exp_q.push_back(ek);
            end else begin
                m_over = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endtask

    // Called at a falling edge; drives one sample and returns at the next falling edge.
    task automatic step(input logic [3:0] r, input logic [3:0] c);
        bit rdy;
        rdy = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        bus.row = r; bus.col = c; bus.key_ready = rdy;
        model_cycle(r, c, rdy);
        @(negedge clk);
    endtask

    task automatic sweep(input logic [15:0] keys, input bit noisy);
        for (int r = 0; r < 4; r++) begin
            if (noisy && $urandom_range(0, 3) == 0)
                step((($urandom_range(0, 1) == 0) ? 4'b0011 : 4'b0000), 4'($urandom_range(0, 15)));
            step(4'(1 << r), keys[r*4 +: 4]);
        end
    endtask

    task automatic sweeps(input logic [15:0] keys, input int n, input bit noisy);
        for (int i = 0; i < n; i++) sweep(keys, noisy);
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_valid"},   bus.key_valid, 0);
        chk({tag, "_code"},    bus.key_code,  0);
        chk({tag, "_held"},    bus.key_held,  0);
        chk({tag, "_overrun"}, bus.overrun,   0);
        model_reset();
        bus.row = 4'd0; bus.col = 4'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: pops one expected code per accepted handshake, and checks the
    // visible outputs against the model every cycle.
    initial begin
        bit       prev_valid = 0;
        int       prev_code  = 0;
        int       e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_valid = 0;
                continue;
            end
            if (prev_valid && bus.key_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_key", prev_code, -1);
                end else begin
                    e = exp_q.pop_front();
                    pops++;
                    chk("key_code_hs", prev_code, e);
                end
            end
            chk("outputs", {bus.key_valid, bus.key_held, bus.overrun, bus.key_code},
                {m_valid, held, m_over, 4'(m_code)});
            prev_valid = bus.key_valid;
            prev_code  = bus.key_code;
        end
    end

    initial begin
        int p0;
        logic [15:0] keys;
        bus.row = 4'd0; bus.col = 4'd0; bus.key_ready = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", bus.key_valid, 0);
        chk("rst_code",  bus.key_code,  0);
        chk("rst_held",  bus.key_held,  0);
        chk("rst_overrun", bus.overrun, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single press of row2/col1, then a clean release
        rdy_mode = 1;
        p0 = pops;
        sweeps(16'h0200, 12, 0);
        chk("single_held", bus.key_held, 1);
        sweeps(16'h0000, N, 0);
        chk("single_emits", pops - p0, 1);
        chk("single_released", bus.key_held, 0);

        // Bounce then a steady run of KEY(5)
        p0 = pops;
        for (int i = 0; i < 7; i++) begin
            sweep(16'h0020, 0);
            sweep(16'h0000, 0);
        end
        chk("bounce_no_emit", pops - p0, 0);
        sweeps(16'h0020, N + 1, 1);
        chk("bounce_emits", pops - p0, 1);

        // Short release then re-press: still the same press
        p0 = pops;
        sweeps(16'h0000, N - 1, 0);
        sweeps(16'h0020, 3, 0);
        chk("repress_held", bus.key_held, 1);
        sweeps(16'h0000, N, 0);
        chk("repress_released", bus.key_held, 0);
        chk("repress_no_emit", pops - p0, 0);
        sweeps(16'h0020, N + 1, 0);
        sweeps(16'h0000, N, 0);
        chk("fresh_press_emits", pops - p0, 1);

        // Multi-key sweeps and invalid rows never emit
        p0 = pops;
        sweeps(16'h0003, 10, 1);
        sweeps(16'h0011, 10, 1);
        sweeps(16'h0000, 2, 1);
        chk("multi_no_emit", pops - p0, 0);

        // Backpressure: second press dropped, code held, overrun sticky
        rdy_mode = 0;
        sweeps(16'h0008, N + 1, 0);
        sweeps(16'h0000, N, 0);
        sweeps(16'h1000, N + 1, 0);
        chk("bp_valid", bus.key_valid, 1);
        chk("bp_code", bus.key_code, 3);
        chk("bp_overrun", bus.overrun, 1);
        rdy_mode = 1;
        step(4'd0, 4'd0);
        chk("bp_drop", bus.key_valid, 0);
        sweeps(16'h0000, N, 0);

        // Reset in PRESS_WAIT, then the still-held key is debounced afresh
        sweeps(16'h0040, 3, 0);
        do_reset("rst_pw");
        p0 = pops;
        sweeps(16'h0040, N + 1, 0);
        chk("post_reset_emits", pops - p0, 1);
        sweeps(16'h0000, N, 0);

        // Reset while a code waits for the consumer
        rdy_mode = 0;
        sweeps(16'h0400, N + 1, 0);
        chk("pre_reset_valid", bus.key_valid, 1);
        do_reset("rst_kv");
        rdy_mode = 1;
        sweeps(16'h0000, 2, 0);

        // Random runs of NONE / single / multi sweeps with random backpressure
        rdy_mode = 2;
        for (int run = 0; run < 40; run++) begin
            int kind = $urandom_range(0, 9);
            keys = 16'h0000;
            if (kind >= 4 && kind <= 8) keys = 16'(1) << $urandom_range(0, 15);
            else if (kind == 9) keys = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            sweeps(keys, $urandom_range(1, 12), 1);
        end

        rdy_mode = 1;
        sweeps(16'h0000, N + 2, 0);
        chk("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
